// File: rtl/gpio_cfg_shift_pkg.sv
// Shared constants for the per-pad GPIO configuration shift block:
// word width, reset value, shadow bit positions and load FSM states.
package gpio_cfg_shift_pkg;

    localparam int CFG_BITS = 13;
    localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403;

    localparam int MGMT_ENA_IDX    = 0;
    localparam int OUTENB_IDX      = 1;
    localparam int HOLDOVER_IDX    = 2;
    localparam int INENB_IDX       = 3;
    localparam int IB_MODE_SEL_IDX = 4;
    localparam int ANALOG_EN_IDX   = 5;
    localparam int ANALOG_SEL_IDX  = 6;
    localparam int ANALOG_POL_IDX  = 7;
    localparam int SLOW_SEL_IDX    = 8;
    localparam int VTRIP_SEL_IDX   = 9;
    localparam int DM_LSB_IDX      = 10;
    localparam int DM_MSB_IDX      = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAFE  = 2'd1,
        ST_APPLY = 2'd2
    } load_state_e;

endpackage

// File: rtl/gpio_cfg_shift.sv
// Per-pad configuration block: serial chain shift register, staged load into
// a shadow word, and the pad/owner data muxing driven by that shadow.
module gpio_cfg_shift #(
    parameter int                  CFG_BITS    = gpio_cfg_shift_pkg::CFG_BITS,
    parameter logic [CFG_BITS-1:0] CFG_DEFAULT = gpio_cfg_shift_pkg::CFG_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_shift,
    input  logic       serial_data_in,
    input  logic       serial_load,
    output logic       serial_data_out,
    input  logic       mgmt_gpio_out,
    input  logic       mgmt_gpio_oeb,
    output logic       mgmt_gpio_in,
    input  logic       user_gpio_out,
    input  logic       user_gpio_oeb,
    output logic       user_gpio_in,
    input  logic       pad_gpio_in,
    output logic       pad_gpio_out,
    output logic       pad_gpio_outenb,
    output logic       pad_gpio_inenb,
    output logic [2:0] pad_gpio_dm,
    output logic       pad_gpio_holdover,
    output logic       pad_gpio_ib_mode_sel,
    output logic       pad_gpio_analog_en,
    output logic       pad_gpio_analog_sel,
    output logic       pad_gpio_analog_pol,
    output logic       pad_gpio_slow_sel,
    output logic       pad_gpio_vtrip_sel
);
    import gpio_cfg_shift_pkg::*;

    logic [CFG_BITS-1:0] shift_q, shift_d;
    logic [CFG_BITS-1:0] pending_q, pending_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    load_state_e         state_q, state_d;

    always_comb begin
        shift_d   = shift_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        state_d   = state_q;
        if (serial_shift)
            shift_d = {shift_q[CFG_BITS-2:0], serial_data_in};
        // pending takes shift_q (pre-shift) so a coincident shift doesn't leak in
        case (state_q)
            ST_IDLE: begin
                if (serial_load) begin
                    pending_d = shift_q;
                    state_d   = ST_SAFE;
                end
            end
            ST_SAFE:  state_d = ST_APPLY;
            ST_APPLY: begin
                shadow_d = pending_q;
                state_d  = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q   <= '0;
            pending_q <= '0;
            shadow_q  <= CFG_DEFAULT;
            state_q   <= ST_IDLE;
        end else begin
            shift_q   <= shift_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            state_q   <= state_d;
        end
    end

    logic mgmt_ena, cfg_outenb, cfg_inenb, owner_in, switching;

    assign mgmt_ena   = shadow_q[MGMT_ENA_IDX];
    assign cfg_outenb = shadow_q[OUTENB_IDX];
    assign cfg_inenb  = shadow_q[INENB_IDX];
    assign owner_in   = pad_gpio_in & ~cfg_inenb;
    assign switching  = (state_q != ST_IDLE);

    assign serial_data_out = shift_q[CFG_BITS-1];

    // Output driver held off while the new owner/mode is being staged
    assign pad_gpio_out    = mgmt_ena ? mgmt_gpio_out : user_gpio_out;
    assign pad_gpio_outenb = switching |
                             (mgmt_ena ? (mgmt_gpio_oeb | cfg_outenb) : user_gpio_oeb);
    assign mgmt_gpio_in    = mgmt_ena ? owner_in : 1'b0;
    assign user_gpio_in    = mgmt_ena ? 1'b0 : owner_in;

    assign pad_gpio_inenb       = cfg_inenb;
    assign pad_gpio_dm          = shadow_q[DM_MSB_IDX:DM_LSB_IDX];
    assign pad_gpio_holdover    = shadow_q[HOLDOVER_IDX];
    assign pad_gpio_ib_mode_sel = shadow_q[IB_MODE_SEL_IDX];
    assign pad_gpio_analog_en   = shadow_q[ANALOG_EN_IDX];
    assign pad_gpio_analog_sel  = shadow_q[ANALOG_SEL_IDX];
    assign pad_gpio_analog_pol  = shadow_q[ANALOG_POL_IDX];
    assign pad_gpio_slow_sel    = shadow_q[SLOW_SEL_IDX];
    assign pad_gpio_vtrip_sel   = shadow_q[VTRIP_SEL_IDX];

endmodule
